// File: rtl/lhs_iter.sv
// Iterative left-hand shifter: shifts, arithmetic shifts and rotates one bit
// position per clock behind a start/busy/done handshake.
module lhs_iter #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = $clog2(WIDTH + 1)
) (
  input  logic               alu_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         operation,
  input  logic [COUNT_W-1:0] count,
  input  logic [WIDTH-1:0]   in,
  input  logic               carry_in,
  output logic [WIDTH-1:0]   out,
  output logic               carry_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ZERO = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  state_t             state_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [2:0]         mode_reg;
  logic               fill_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               carry_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [COUNT_W-1:0] eff_count;
  logic               is_zero;
  logic               is_pass;
  logic [WIDTH-1:0]   step_r;
  logic               step_c;

  // Counts above WIDTH saturate for every mode, rotates included.
  assign eff_count = (count > COUNT_W'(WIDTH)) ? COUNT_W'(WIDTH) : count;
  assign is_zero   = (operation == OP_ZERO);
  assign is_pass   = (operation == OP_PASS) || (operation == OP_RSVD) ||
                     (eff_count == '0);

  always_comb begin
    step_r = out_reg;
    step_c = carry_reg;
    case (mode_reg)
      OP_SHL: begin
        step_c = out_reg[WIDTH-1];
        step_r = {out_reg[WIDTH-2:0], fill_reg};
      end
      OP_SHR: begin
        step_c = out_reg[0];
        step_r = {fill_reg, out_reg[WIDTH-1:1]};
      end
      OP_ASR: begin
        step_c = out_reg[0];
        step_r = {out_reg[WIDTH-1], out_reg[WIDTH-1:1]};
      end
      OP_ROL: begin
        step_c = out_reg[WIDTH-1];
        step_r = {out_reg[WIDTH-2:0], out_reg[WIDTH-1]};
      end
      OP_ROR: begin
        step_c = out_reg[0];
        step_r = {out_reg[0], out_reg[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      mode_reg      <= OP_PASS;
      fill_reg      <= 1'b0;
      out_reg       <= '0;
      carry_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // ZERO wins over a zero count: the mode itself defines the result.
            if (is_zero) begin
              out_reg   <= '0;
              carry_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else if (is_pass) begin
              out_reg   <= in;
              carry_reg <= carry_in;
              done_reg  <= 1'b1;
            end else begin
              out_reg       <= in;
              carry_reg     <= carry_in;
              remaining_reg <= eff_count;
              mode_reg      <= operation;
              fill_reg      <= carry_in;
              busy_reg      <= 1'b1;
              state_reg     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          out_reg       <= step_r;
          carry_reg     <= step_c;
          remaining_reg <= remaining_reg - 1'b1;
          if (remaining_reg == COUNT_W'(1)) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out       = out_reg;
  assign carry_out = carry_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_lhs_iter.sv
// Directed bench for lhs_iter (WIDTH=8) with hand-computed expected results.
module tb_lhs_iter;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = $clog2(WIDTH + 1);

  logic               alu_clk;
  logic               reset;
  logic               start;
  logic [2:0]         operation;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   in;
  logic               carry_in;
  logic [WIDTH-1:0]   out;
  logic               carry_out;
  logic               busy;
  logic               done;

  int compared = 0;
  int mismatched = 0;

  lhs_iter #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .alu_clk  (alu_clk),
    .reset    (reset),
    .start    (start),
    .operation(operation),
    .count    (count),
    .in       (in),
    .carry_in (carry_in),
    .out      (out),
    .carry_out(carry_out),
    .busy     (busy),
    .done     (done)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] e_out,
                               input logic e_c, input logic e_busy,
                               input logic e_done);
    check({tag, ".out"},  32'(out),       32'(e_out));
    check({tag, ".c"},    32'(carry_out), 32'(e_c));
    check({tag, ".busy"}, 32'(busy),      32'(e_busy));
    check({tag, ".done"}, 32'(done),      32'(e_done));
  endtask

  // Latency counts edges from the accepting edge up to the one raising done.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [7:0] a, input logic cin,
                        input logic [COUNT_W-1:0] cnt, input logic [7:0] e_out,
                        input logic e_c, input int e_lat);
    int lat;
    logic busy_seen;
    operation = op; in = a; carry_in = cin; count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 20) begin
      tick();
      lat++;
      busy_seen = busy_seen | busy;
    end
    $display("op %s: in=%02h cnt=%0d -> out=%02h c=%0b latency=%0d",
             tag, a, cnt, out, carry_out, lat);
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".busy_seen"}, 32'(busy_seen), 32'(e_lat > 1));
    check_outputs(tag, e_out, e_c, 1'b0, 1'b1);
    tick();
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".hold"}, 32'(out), 32'(e_out));
  endtask

  initial begin
    logic done_seen;
    reset = 1'b1; start = 1'b1; operation = 3'b001; in = 8'h96;
    carry_in = 1'b1; count = 4'd3;

    // Reset held with start high: nothing accepted.
    tick();
    check_outputs("rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_outputs("rst2", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    check_outputs("rst_rel", 8'h00, 1'b0, 1'b0, 1'b0);
    $display("reset: out=%02h busy=%0b done=%0b", out, busy, done);

    // SHL with intermediate values.
    operation = 3'b001; in = 8'h96; carry_in = 1'b1; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_outputs("shl_e0", 8'h96, 1'b1, 1'b1, 1'b0);
    tick();
    check_outputs("shl_e1", 8'h2D, 1'b1, 1'b1, 1'b0);
    tick();
    check_outputs("shl_e2", 8'h5B, 1'b0, 1'b1, 1'b0);
    tick();
    check_outputs("shl_e3", 8'hB7, 1'b0, 1'b0, 1'b1);
    tick();
    check_outputs("shl_e4", 8'hB7, 1'b0, 1'b0, 1'b0);
    $display("op shl_steps: final out=%02h c=%0b", out, carry_out);

    run_op("asr",      3'b100, 8'h84, 1'b0, 4'd2,  8'hE1, 1'b0, 3);
    run_op("shr",      3'b010, 8'h84, 1'b0, 4'd2,  8'h21, 1'b0, 3);
    run_op("ror_sat",  3'b110, 8'hA5, 1'b0, 4'd9,  8'hA5, 1'b1, 9);
    run_op("rol",      3'b101, 8'h81, 1'b0, 4'd1,  8'h03, 1'b1, 2);
    run_op("shl_full", 3'b001, 8'hFF, 1'b0, 4'd8,  8'h00, 1'b1, 9);
    run_op("asr_sat",  3'b100, 8'h80, 1'b1, 4'd15, 8'hFF, 1'b1, 9);
    run_op("shr_k0",   3'b010, 8'h3C, 1'b1, 4'd0,  8'h3C, 1'b1, 1);
    run_op("zero",     3'b011, 8'hFF, 1'b1, 4'd3,  8'h00, 1'b0, 1);
    run_op("rsvd",     3'b111, 8'h5A, 1'b1, 4'd4,  8'h5A, 1'b1, 1);
    run_op("pass",     3'b000, 8'h12, 1'b0, 4'd2,  8'h12, 1'b0, 1);

    // Start mid-SHIFT with a different operand is ignored.
    operation = 3'b001; in = 8'h96; carry_in = 1'b1; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    operation = 3'b011; in = 8'h00; carry_in = 1'b0; count = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_outputs("ign_e2", 8'h5B, 1'b0, 1'b1, 1'b0);
    tick();
    check_outputs("ign_done", 8'hB7, 1'b0, 1'b0, 1'b1);
    $display("op ignore_start: out=%02h c=%0b", out, carry_out);

    // Reset after two steps of a count-5 SHL aborts without done.
    tick();
    operation = 3'b001; in = 8'h96; carry_in = 1'b1; count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_outputs("abort_pre", 8'h5B, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seen = done_seen | done | busy;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    $display("op abort: out=%02h busy=%0b", out, busy);

    // Start held across done: second operation accepted with no gap.
    operation = 3'b101; in = 8'h81; carry_in = 1'b0; count = 4'd1; start = 1'b1;
    tick();
    check_outputs("b2b_e0", 8'h81, 1'b0, 1'b1, 1'b0);
    operation = 3'b110; in = 8'h01; count = 4'd1;
    tick();
    check_outputs("b2b_e1", 8'h03, 1'b1, 1'b0, 1'b1);
    tick();
    check_outputs("b2b_e2", 8'h01, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_outputs("b2b_e3", 8'h80, 1'b1, 1'b0, 1'b1);
    tick();
    check_outputs("b2b_e4", 8'h80, 1'b1, 1'b0, 1'b0);
    $display("op back_to_back: out=%02h c=%0b", out, carry_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lhs_iter.md
# lhs_iter

Parametrised, iterative successor to the single-step left-hand shifter in the ALU operand path. It takes one operand, a shift/rotate mode and a shift count. It then steps the result one bit position per `alu_clk` cycle, behind a start/busy/done handshake. It adds three things the single-step shifter lacks: multi-bit counts, arithmetic right shift and rotates. The ALU sequencer drives `start` and waits for `done` before sampling `out`/`carry_out`.

## Interface
- `WIDTH`, 8: operand and result width in bits; legal range 2 and up.
- `COUNT_W`, `$clog2(WIDTH+1)`: width of the shift-count input.
- `alu_clk`  in  1: ALU clock; all state changes on its rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: request; sampled only while idle (`busy`=0).
- `operation`  in  3: mode, latched on accepted `start`.
- `count`  in  COUNT_W: shift amount, latched on accepted `start`.
- `in`  in  WIDTH: operand, latched on accepted `start`.
- `carry_in`  in  1: fill bit for SHL/SHR, latched on accepted `start`.
- `out`  out  WIDTH: result register.
- `carry_out`  out  1: last bit shifted or rotated out.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; `out`/`carry_out` final.

## Operation
- Modes of `operation`:
  - 000 PASS
  - 001 SHL (fill `carry_in`)
  - 010 SHR (fill `carry_in`)
  - 011 ZERO
  - 100 ASR (fill sign bit)
  - 101 ROL
  - 110 ROR
  - 111 reserved, behaves as PASS
- Effective count k = min(`count`, WIDTH). Counts above WIDTH saturate for every mode, including rotates.
- One step per cycle on working register R and carry C:
  - SHL: C=R[W-1], R={R[W-2:0],cin}
  - SHR: C=R[0], R={cin,R[W-1:1]}
  - ASR: C=R[0], R={R[W-1],R[W-1:1]}
  - ROL: C=R[W-1], R={R[W-2:0],R[W-1]}
  - ROR: C=R[0], R={R[0],R[W-1:1]}
- `out` is R and `carry_out` is C. There is no separate copy.
- The following complete in a single cycle:
  - PASS, reserved, or k=0: out=in, carry_out=carry_in.
  - ZERO: out=0, carry_out=0.
- States:
  - IDLE: `busy`=0. Accepted `start` latches the inputs.
    - Single-cycle case: write the result, pulse `done`, stay in IDLE.
    - Otherwise: R=in, C=carry_in, remaining=k, go to SHIFT.
  - SHIFT: `busy`=1. Each edge performs one step and decrements remaining. On the edge where remaining goes 1→0: go to IDLE, `busy`=0, pulse `done`.
- `start` while `busy`=1 is ignored; no queuing. Input changes while busy have no effect.
- `out`/`carry_out` hold their last value while idle until the next accepted `start`.
- During SHIFT, `out`/`carry_out` show intermediate values. Consumers use them only with `done`.

## Timing
- Reset values: out=0, carry_out=0, busy=0, done=0, state IDLE, remaining=0.
- Reset mid-SHIFT aborts the operation: registers go to reset values, no `done` pulse. Reset wins over a simultaneous `start`.
- Start accepted at edge E0:
  - Single-cycle case: result and `done`=1 appear after E0; `done` drops after E1.
  - k≥1: after E0, `busy`=1 and out=in. After edge Ek, the final result is valid, `busy`=0 and `done`=1. Latency is k edges, maximum WIDTH.
- `done` and `busy` are never high together.
- A new `start` may be presented in the cycle `done` is high (IDLE). It is accepted at that edge, giving back-to-back operation with no dead cycle.
- `done` is high exactly one cycle per accepted `start`.

## Test plan
All cases use WIDTH=8.
- Reset: assert `reset` 2 cycles with `start`=1 → out=0x00, carry_out=0, busy=0, done=0 throughout; `start` not accepted.
- SHL, in=0x96, carry_in=1, count=3 → busy for 3 cycles; intermediate out 0x2D/c1, 0x5B/c0; final out=0xB7, carry_out=0, `done` one cycle after 3rd step edge.
- ASR, in=0x84, count=2 → out=0xE1, carry_out=0, done after 2 edges. SHR of the same operand with carry_in=0 → out=0x21, carry_out=0.
- ROR, in=0xA5, count=9 → saturates to 8, out=0xA5, carry_out=1, 8-cycle latency. ROL, in=0x81, count=1 → out=0x03, carry_out=1.
- Single-cycle cases:
  - SHR, count=0, in=0x3C, carry_in=1 → out=0x3C, carry_out=1, done next cycle, busy never high.
  - ZERO → out=0x00, carry_out=0.
  - op=111 → PASS.
- Handshake:
  - `start` pulsed mid-SHIFT with different operand → ignored, original result intact.
  - `reset` at step 2 of a count-5 SHL → outputs 0, no `done`.
  - `start` held high across `done` → second operation accepted with no gap.
